// File: rtl/frame_len_queue_pkg.sv
// Shared constants for the bit-tick pacing logic: frame sizing, MTU and FSM encodings.
// The timetable and current-value translator blocks take their constants from here too.
package frame_len_queue_pkg;

  localparam int TICKS_PER_UNIT = 16;
  localparam int MTU_UNITS      = 95;
  localparam int LEN_W          = 8;
  localparam int TXCNT_W        = 12;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_TX   = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  // The tick counter holds (remaining ticks - 1), so 0 marks the last tick of the frame.
  function automatic logic [TXCNT_W-1:0] tick_load(input logic [LEN_W-1:0] len);
    return TXCNT_W'(len) * TXCNT_W'(TICKS_PER_UNIT) - TXCNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_len_queue_len_fifo.sv
// Synchronous length FIFO. The head entry is always presented on dout_o.
// Callers must not push when full or pop when empty.
module frame_len_queue_len_fifo
  import frame_len_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              cnt_clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [LEN_W-1:0]  din_i,
  output logic [LEN_W-1:0]  dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [LEN_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;

  // Storage carries no reset; the count masks stale entries.
  always_ff @(posedge cnt_clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge cnt_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/frame_len_queue.sv
// Per-queue frame-length store: presents the head length to the arbiter and times
// the granted frame at 16 ticks per unit, with a one-tick zero gap after every frame.
module frame_len_queue
  import frame_len_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int MAX_LEN = MTU_UNITS
) (
  input  logic              cnt_clk,
  input  logic              rst_n,
  input  logic              push_valid_i,
  input  logic [LEN_W-1:0]  push_len_i,
  output logic              push_ready_o,
  input  logic              go_i,
  output logic [LEN_W-1:0]  pkt_len_o,
  output logic              tx_busy_o,
  output logic              tx_done_o,
  output logic              tx_abort_o,
  output logic              drop_o,
  output logic              len_err_o,
  output logic [ADDR_W:0]   count_o
);

  logic [1:0]         state_q, state_d;
  logic [TXCNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [LEN_W-1:0]   tx_len_q, tx_len_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic               drop_q, len_err_q;

  logic               full, empty, len_ok, push_ok, pop;
  logic [LEN_W-1:0]   head;

  // Rejections look at the current fill level only, so a same-tick pop never rescues a full push.
  assign len_ok  = (push_len_i != '0) && (push_len_i <= LEN_W'(MAX_LEN));
  assign push_ok = push_valid_i && len_ok && !full;
  assign pop     = (state_q == ST_IDLE) && go_i && !empty;

  frame_len_queue_len_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .cnt_clk (cnt_clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .pop_i   (pop),
    .din_i   (push_len_i),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    tx_len_d = tx_len_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_len_d = head;
          tx_cnt_d = tick_load(head);
          busy_d   = 1'b1;
          state_d  = ST_TX;
        end
      end
      ST_TX: begin
        if (!go_i) begin
          abort_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_GAP;
        end else if (tx_cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_GAP;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cnt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_cnt_q  <= '0;
      tx_len_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      drop_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_len_q  <= tx_len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      drop_q    <= push_valid_i && len_ok && full;
      len_err_q <= push_valid_i && !len_ok;
    end
  end

  always_comb begin
    pkt_len_o = '0;
    case (state_q)
      ST_IDLE: pkt_len_o = empty ? '0 : head;
      ST_TX:   pkt_len_o = tx_len_q;
      default: pkt_len_o = '0;
    endcase
  end

  assign push_ready_o = !full;
  assign tx_busy_o    = busy_q;
  assign tx_done_o    = done_q;
  assign tx_abort_o   = abort_q;
  assign drop_o       = drop_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_frame_len_queue.sv
// Self-checking bench for frame_len_queue: table-driven pushes plus a scoreboard of
// queued lengths that is popped and compared whenever a frame starts on the wire.
module tb_frame_len_queue;

  logic       cnt_clk = 1'b0;
  logic       rst_n;
  logic       push_valid_i;
  logic [7:0] push_len_i;
  logic       push_ready_o;
  logic       go_i;
  logic [7:0] pkt_len_o;
  logic       tx_busy_o, tx_done_o, tx_abort_o, drop_o, len_err_o;
  logic [3:0] count_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] len;
    bit         exp_err;
    bit         exp_drop;
  } push_vec_t;

  frame_len_queue dut (
    .cnt_clk      (cnt_clk),
    .rst_n        (rst_n),
    .push_valid_i (push_valid_i),
    .push_len_i   (push_len_i),
    .push_ready_o (push_ready_o),
    .go_i         (go_i),
    .pkt_len_o    (pkt_len_o),
    .tx_busy_o    (tx_busy_o),
    .tx_done_o    (tx_done_o),
    .tx_abort_o   (tx_abort_o),
    .drop_o       (drop_o),
    .len_err_o    (len_err_o),
    .count_o      (count_o)
  );

  always #5 cnt_clk = ~cnt_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] len, input bit exp_err, input bit exp_drop);
    push_valid_i = 1'b1;
    push_len_i   = len;
    tick();
    push_valid_i = 1'b0;
    if (!exp_err && !exp_drop) exp_q.push_back(int'(len));
    check("len_err", int'(len_err_o), int'(exp_err));
    check("drop", int'(drop_o), int'(exp_drop));
    check("count", int'(count_o), exp_q.size());
    $display("push len=%0d len_err=%0d drop=%0d count=%0d", len, len_err_o, drop_o, count_o);
  endtask

  // Grant from IDLE; optionally push in the same tick as the pop.
  task automatic start_frame(input logic [7:0] plen, output int len);
    go_i = 1'b1;
    if (plen != 0) begin
      push_valid_i = 1'b1;
      push_len_i   = plen;
    end
    tick();
    push_valid_i = 1'b0;
    len = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
    if (plen != 0) exp_q.push_back(int'(plen));
    check("tx_start_busy", int'(tx_busy_o), 1);
    check("tx_start_len", int'(pkt_len_o), len);
    check("tx_start_count", int'(count_o), exp_q.size());
    check("tx_start_ready", int'(push_ready_o), int'(exp_q.size() != 8));
  endtask

  task automatic finish_frame(input int len, input bit hold_go);
    int n = 1;
    int bad_len = 0;
    while (tx_busy_o && n < 2000) begin
      tick();
      if (tx_busy_o) begin
        n++;
        if (pkt_len_o != 8'(len)) bad_len++;
      end
    end
    check("tx_ticks", n, 16 * len);
    check("tx_len_held", bad_len, 0);
    check("gap_done", int'(tx_done_o), 1);
    check("gap_abort", int'(tx_abort_o), 0);
    check("gap_pkt_len", int'(pkt_len_o), 0);
    if (!hold_go) go_i = 1'b0;
    tick();
    check("done_pulse_end", int'(tx_done_o), 0);
    check("next_head", int'(pkt_len_o), (exp_q.size() != 0) ? exp_q[0] : 0);
    $display("frame len=%0d ticks=%0d next_pkt_len=%0d count=%0d", len, n, pkt_len_o, count_o);
  endtask

  task automatic run_frame(input bit hold_go);
    int len;
    start_frame(8'd0, len);
    finish_frame(len, hold_go);
  endtask

  initial begin
    push_vec_t len_tbl[6];
    int len;
    len_tbl[0] = '{8'd0,   1'b1, 1'b0};
    len_tbl[1] = '{8'd96,  1'b1, 1'b0};
    len_tbl[2] = '{8'd255, 1'b1, 1'b0};
    len_tbl[3] = '{8'd95,  1'b0, 1'b0};
    len_tbl[4] = '{8'd1,   1'b0, 1'b0};
    len_tbl[5] = '{8'd128, 1'b1, 1'b0};

    rst_n = 1'b0; push_valid_i = 1'b0; push_len_i = '0; go_i = 1'b0;
    repeat (2) tick();
    check("rst_pkt_len", int'(pkt_len_o), 0);
    check("rst_busy", int'(tx_busy_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_ready", int'(push_ready_o), 1);
    check("rst_pulses", int'({tx_done_o, tx_abort_o, drop_o, len_err_o}), 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back frames with go held throughout.
    do_push(8'd4, 0, 0);
    check("head_after_push", int'(pkt_len_o), 4);
    do_push(8'd8, 0, 0);
    run_frame(1'b1);
    run_frame(1'b0);

    // Fill to capacity, overflow, then drain part way.
    for (int i = 0; i < 8; i++) do_push(8'd5, 0, 0);
    check("full_ready", int'(push_ready_o), 0);
    do_push(8'd5, 0, 1);
    check("full_ready_after_drop", int'(push_ready_o), 0);
    for (int i = 0; i < 5; i++) run_frame(1'b0);

    // Push coincident with pop at count 3, then drain across the pointer wrap.
    check("count_before_coincident", int'(count_o), 3);
    start_frame(8'd9, len);
    finish_frame(len, 1'b0);
    do_push(8'd10, 0, 0);
    while (exp_q.size() != 0) run_frame(1'b0);

    // Length legality table, then the longest and shortest frames.
    foreach (len_tbl[i]) do_push(len_tbl[i].len, len_tbl[i].exp_err, len_tbl[i].exp_drop);
    run_frame(1'b0);
    run_frame(1'b0);

    // go lost 20 ticks into a len-4 frame.
    do_push(8'd4, 0, 0);
    do_push(8'd3, 0, 0);
    start_frame(8'd0, len);
    repeat (19) tick();
    go_i = 1'b0;
    tick();
    check("abort_pulse", int'(tx_abort_o), 1);
    check("abort_done", int'(tx_done_o), 0);
    check("abort_busy", int'(tx_busy_o), 0);
    check("abort_gap_len", int'(pkt_len_o), 0);
    tick();
    check("abort_pulse_end", int'(tx_abort_o), 0);
    check("abort_next_head", int'(pkt_len_o), 3);
    check("abort_count", int'(count_o), 1);
    $display("abort len=%0d next_pkt_len=%0d count=%0d", len, pkt_len_o, count_o);
    run_frame(1'b0);

    // Asynchronous reset mid-frame, then a grant against an empty FIFO.
    do_push(8'd6, 0, 0);
    do_push(8'd2, 0, 0);
    start_frame(8'd0, len);
    repeat (29) tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy", int'(tx_busy_o), 0);
    check("mid_rst_pkt_len", int'(pkt_len_o), 0);
    check("mid_rst_count", int'(count_o), 0);
    check("mid_rst_ready", int'(push_ready_o), 1);
    check("mid_rst_pulses", int'({tx_done_o, tx_abort_o, drop_o, len_err_o}), 0);
    $display("reset mid-frame pkt_len=%0d count=%0d", pkt_len_o, count_o);
    tick();
    rst_n = 1'b1;
    go_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_go_busy", int'(tx_busy_o), 0);
      check("empty_go_pulses", int'({tx_done_o, tx_abort_o}), 0);
      check("empty_go_pkt_len", int'(pkt_len_o), 0);
    end
    go_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
